fetch_sequencer: RTL and testbench

FETCH_SEQUENCER -- requirements
Module: fetch_sequencer

---
 rtl/fetch_seq_pkg.sv | 27 ++
 rtl/fetch_out_buf.sv | 49 ++++
 rtl/fetch_sequencer.sv | 194 +++++++++++++++++++
 tb/tb_fetch_sequencer.sv | 352 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fetch_seq_pkg.sv
// Shared definitions for the instruction fetch sequencer: FSM state encoding,
// instruction size and the redirect alignment helper.
package fetch_seq_pkg;

  localparam int unsigned INSTR_BYTES = 4;

  localparam logic [2:0] ST_IDLE  = 3'd0;
  localparam logic [2:0] ST_REQ   = 3'd1;
  localparam logic [2:0] ST_WAIT  = 3'd2;
  localparam logic [2:0] ST_HOLD  = 3'd3;
  localparam logic [2:0] ST_DROP  = 3'd4;
  localparam logic [2:0] ST_FAULT = 3'd5;

  typedef enum logic [2:0] {
    S_IDLE  = ST_IDLE,
    S_REQ   = ST_REQ,
    S_WAIT  = ST_WAIT,
    S_HOLD  = ST_HOLD,
    S_DROP  = ST_DROP,
    S_FAULT = ST_FAULT
  } fetch_state_e;

  function automatic logic addr_misaligned(input logic [1:0] i_lsb);
    return (i_lsb != 2'b00);
  endfunction

endpackage

// File: rtl/fetch_out_buf.sv
// Single-entry instruction output register with valid/ready handshake toward decode.
// A flush (redirect) wins over a load, and a load wins over a pop.
module fetch_out_buf #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic              clk,
  input  logic              async_rst_n,
  input  logic              i_en,
  input  logic              i_load,
  input  logic              i_flush,
  input  logic              i_pop,
  input  logic [DATA_W-1:0] i_data,
  input  logic [ADDR_W-1:0] i_addr,
  output logic              o_valid,
  output logic [DATA_W-1:0] o_data,
  output logic [ADDR_W-1:0] o_addr
);

  logic              r_valid;
  logic [DATA_W-1:0] r_data;
  logic [ADDR_W-1:0] r_addr;

  // Output word, its address and the valid flag; everything frozen when i_en is low.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_valid <= 1'b0;
      r_data  <= {DATA_W{1'b0}};
      r_addr  <= {ADDR_W{1'b0}};
    end else if (i_en) begin
      if (i_flush) begin
        r_valid <= 1'b0;
      end else if (i_load) begin
        r_valid <= 1'b1;
        r_data  <= i_data;
        r_addr  <= i_addr;
      end else if (i_pop) begin
        r_valid <= 1'b0;
      end else begin
        r_valid <= r_valid;
      end
    end
  end

  assign o_valid = r_valid;
  assign o_data  = r_data;
  assign o_addr  = r_addr;

endmodule

// File: rtl/fetch_sequencer.sv
// Instruction fetch sequencer: one outstanding imem request, redirect handling and
// response dropping. FETCH_SEQ_MISALIGN_TRAP_EN enables the misaligned-redirect trap.
module fetch_sequencer
  import fetch_seq_pkg::*;
#(
  parameter int unsigned                INSTR_ADDR_WIDTH = 32,
  parameter int unsigned                INSTR_WIDTH      = 32,
  parameter logic [INSTR_ADDR_WIDTH-1:0] RESET_VECTOR    = {INSTR_ADDR_WIDTH{1'b0}}
) (
  input  logic                        clk,
  input  logic                        async_rst_n,
  input  logic                        clk_en,
  input  logic                        stall,
  input  logic                        redirect_valid,
  input  logic [INSTR_ADDR_WIDTH-1:0] redirect_addr,
  output logic                        imem_req_valid,
  input  logic                        imem_req_ready,
  output logic [INSTR_ADDR_WIDTH-1:0] imem_req_addr,
  input  logic                        imem_rsp_valid,
  input  logic [INSTR_WIDTH-1:0]      imem_rsp_data,
  output logic                        instr_valid,
  input  logic                        instr_ready,
  output logic [INSTR_WIDTH-1:0]      instr_data,
  output logic [INSTR_ADDR_WIDTH-1:0] instr_addr,
  output logic                        misalign_fault
);

  localparam logic [INSTR_ADDR_WIDTH-1:0] PC_STEP = INSTR_ADDR_WIDTH'(INSTR_BYTES);

  fetch_state_e                r_state;
  fetch_state_e                w_state_next;
  fetch_state_e                w_resume;
  logic [INSTR_ADDR_WIDTH-1:0] r_pc;
  logic [INSTR_ADDR_WIDTH-1:0] w_pc_next;
  logic [INSTR_ADDR_WIDTH-1:0] r_req_addr;
  logic [INSTR_ADDR_WIDTH-1:0] w_redir_addr;
  logic                        r_req_valid;
  logic                        r_redir_pending;
  logic                        w_pending_next;
  logic                        r_misalign_fault;
  logic                        w_misalign;
  logic                        w_redir_ok;
  logic                        w_hs;
  logic                        w_capture;
  logic                        w_flush;

`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
  assign w_redir_addr = redirect_addr;
  assign w_misalign   = redirect_valid & addr_misaligned(redirect_addr[1:0]);
`else
  assign w_redir_addr = redirect_addr & {{(INSTR_ADDR_WIDTH-2){1'b1}}, 2'b00};
  assign w_misalign   = 1'b0;
`endif

  assign w_redir_ok = redirect_valid & ~w_misalign;
  assign w_hs       = (r_state == S_REQ) & imem_req_ready;

  // Next-state, next-pc and output-buffer control; redirect outranks every other event.
  always_comb begin
    w_state_next   = r_state;
    w_pc_next      = r_pc;
    w_pending_next = r_redir_pending;
    w_capture      = 1'b0;
    w_flush        = redirect_valid;
    w_resume       = stall ? S_IDLE : S_REQ;
    if (w_misalign) begin
      w_state_next   = S_FAULT;
      w_pending_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_redir_ok) begin
            w_pc_next = w_redir_addr;
          end else if (!stall) begin
            w_state_next = S_REQ;
          end else begin
            w_state_next = S_IDLE;
          end
        end
        S_REQ: begin
          // The address on the bus stays put; a redirect only retargets pc and
          // marks the in-flight fetch for dropping.
          if (w_hs) begin
            w_pending_next = 1'b0;
            if (w_redir_ok) begin
              w_pc_next    = w_redir_addr;
              w_state_next = S_DROP;
            end else if (r_redir_pending) begin
              w_state_next = S_DROP;
            end else begin
              w_pc_next    = r_pc + PC_STEP;
              w_state_next = S_WAIT;
            end
          end else if (w_redir_ok) begin
            w_pc_next      = w_redir_addr;
            w_pending_next = 1'b1;
          end else begin
            w_state_next = S_REQ;
          end
        end
        S_WAIT: begin
          if (w_redir_ok) begin
            w_pc_next    = w_redir_addr;
            w_state_next = imem_rsp_valid ? S_REQ : S_DROP;
          end else if (imem_rsp_valid) begin
            w_capture    = 1'b1;
            w_state_next = S_HOLD;
          end else begin
            w_state_next = S_WAIT;
          end
        end
        S_HOLD: begin
          if (w_redir_ok) begin
            w_pc_next    = w_redir_addr;
            w_state_next = w_resume;
          end else if (instr_ready) begin
            w_state_next = w_resume;
          end else begin
            w_state_next = S_HOLD;
          end
        end
        S_DROP: begin
          if (w_redir_ok) begin
            w_pc_next = w_redir_addr;
          end else begin
            w_pc_next = r_pc;
          end
          if (imem_rsp_valid) begin
            w_state_next = w_resume;
          end else begin
            w_state_next = S_DROP;
          end
        end
        S_FAULT: begin
          if (w_redir_ok) begin
            w_pc_next    = w_redir_addr;
            w_state_next = w_resume;
          end else begin
            w_state_next = S_FAULT;
          end
        end
        default: begin
          w_state_next   = S_IDLE;
          w_pending_next = 1'b0;
        end
      endcase
    end
  end

  // FSM, pc, request register and fault pulse; the request address is latched only on entry to REQ.
  always_ff @(posedge clk or negedge async_rst_n) begin
    if (!async_rst_n) begin
      r_state          <= S_IDLE;
      r_pc             <= RESET_VECTOR;
      r_req_addr       <= RESET_VECTOR;
      r_req_valid      <= 1'b0;
      r_redir_pending  <= 1'b0;
      r_misalign_fault <= 1'b0;
    end else if (clk_en) begin
      r_state          <= w_state_next;
      r_pc             <= w_pc_next;
      r_redir_pending  <= w_pending_next;
      r_req_valid      <= (w_state_next == S_REQ);
      r_misalign_fault <= w_misalign;
      if ((w_state_next == S_REQ) && (r_state != S_REQ)) begin
        r_req_addr <= w_pc_next;
      end else begin
        r_req_addr <= r_req_addr;
      end
    end
  end

  fetch_out_buf #(
    .ADDR_W (INSTR_ADDR_WIDTH),
    .DATA_W (INSTR_WIDTH)
  ) u_out_buf (
    .clk         (clk),
    .async_rst_n (async_rst_n),
    .i_en        (clk_en),
    .i_load      (w_capture),
    .i_flush     (w_flush),
    .i_pop       (instr_ready),
    .i_data      (imem_rsp_data),
    .i_addr      (r_req_addr),
    .o_valid     (instr_valid),
    .o_data      (instr_data),
    .o_addr      (instr_addr)
  );

  assign imem_req_valid = r_req_valid;
  assign imem_req_addr  = r_req_addr;
  assign misalign_fault = r_misalign_fault;

endmodule

// File: tb/tb_fetch_sequencer.sv
// Self-checking bench for fetch_sequencer: directed scenarios plus a randomized
// stream checked against a transaction-level model of the expected fetch order.
module tb_fetch_sequencer;

  logic        clk;
  logic        async_rst_n;
  logic        clk_en;
  logic        stall;
  logic        redirect_valid;
  logic [31:0] redirect_addr;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr_data;
  logic [31:0] instr_addr;
  logic        misalign_fault;

  fetch_sequencer dut (
    .clk            (clk),
    .async_rst_n    (async_rst_n),
    .clk_en         (clk_en),
    .stall          (stall),
    .redirect_valid (redirect_valid),
    .redirect_addr  (redirect_addr),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr_data     (instr_data),
    .instr_addr     (instr_addr),
    .misalign_fault (misalign_fault)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int          n_cmp;
  int          n_err;
  int          cyc;
  logic [31:0] req_log[$];
  logic [31:0] del_addr[$];
  logic [31:0] del_data[$];
  int          del_cyc[$];
  logic        pend;
  logic [31:0] paddr;
  int          cnt;
  int          lat;
  logic        rand_lat;
  logic [31:0] watch_addr;
  logic        shown_watch;

  // Instruction memory contents as a pure function of the address.
  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a ^ 32'hC3A5_0F96) + 32'h0001_0001;
  endfunction

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One clock: log handshakes/deliveries, check request stability, run the memory model.
  task automatic cycle();
    logic        hs;
    logic        pop;
    logic        rsp_now;
    logic        hold_req;
    logic [31:0] a_req;
    hs       = imem_req_valid && imem_req_ready && clk_en;
    pop      = instr_valid && instr_ready && clk_en;
    rsp_now  = imem_rsp_valid && clk_en;
    hold_req = imem_req_valid && !hs;
    a_req    = imem_req_addr;
    if (hs) begin
      check("one_outstanding", {31'd0, pend}, 32'd0);
      req_log.push_back(a_req);
    end
    if (pop) begin
      del_addr.push_back(instr_addr);
      del_data.push_back(instr_data);
      del_cyc.push_back(cyc);
    end
    @(posedge clk);
    #1;
    cyc++;
    if (hold_req) begin
      check("req_valid_stable", {31'd0, imem_req_valid}, 32'd1);
      check("req_addr_stable", imem_req_addr, a_req);
    end
    if (instr_valid && (instr_addr == watch_addr)) shown_watch = 1'b1;
    if (rsp_now) begin
      imem_rsp_valid = 1'b0;
      pend = 1'b0;
    end
    if (hs) begin
      pend  = 1'b1;
      paddr = a_req;
      cnt   = rand_lat ? int'($urandom_range(0, 3)) : lat;
    end
    if (pend && !imem_rsp_valid) begin
      if (cnt == 0) begin
        imem_rsp_valid = 1'b1;
        imem_rsp_data  = memf(paddr);
      end else begin
        cnt--;
      end
    end
  endtask

  task automatic run_until_req(input int n);
    for (int k = 0; k < 60 && req_log.size() < n; k++) cycle();
    check("timeout_req", {31'd0, (req_log.size() >= n)}, 32'd1);
  endtask

  task automatic run_until_del(input int n);
    for (int k = 0; k < 60 && del_addr.size() < n; k++) cycle();
    check("timeout_del", {31'd0, (del_addr.size() >= n)}, 32'd1);
  endtask

  task automatic run_until_ivalid();
    for (int k = 0; k < 30 && !instr_valid; k++) cycle();
    check("timeout_ivalid", {31'd0, instr_valid}, 32'd1);
  endtask

  // Asynchronous reset with outputs checked before any clock edge; stall is left as the caller set it.
  task automatic do_reset();
    #2;
    async_rst_n    = 1'b0;
    clk_en         = 1'b1;
    redirect_valid = 1'b0;
    redirect_addr  = 32'd0;
    imem_req_ready = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = 32'd0;
    instr_ready    = 1'b1;
    pend           = 1'b0;
    cnt            = 0;
    lat            = 0;
    rand_lat       = 1'b0;
    watch_addr     = 32'hFFFF_FFFF;
    shown_watch    = 1'b0;
    #1;
    check("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    check("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    check("rst_instr_data", instr_data, 32'd0);
    check("rst_instr_addr", instr_addr, 32'd0);
    check("rst_misalign", {31'd0, misalign_fault}, 32'd0);
    @(posedge clk);
    #1;
    async_rst_n = 1'b1;
    req_log.delete();
    del_addr.delete();
    del_data.delete();
    del_cyc.delete();
    cyc = 0;
  endtask

  initial begin
    async_rst_n = 1'b1;
    n_cmp = 0;
    n_err = 0;
    cyc   = 0;
    stall = 1'b0;

    // Straight-line fetch with a 1-cycle memory
    do_reset();
    run_until_del(3);
    for (int i = 0; i < 3; i++) begin
      check("s1_req_addr", qat(req_log, i), 32'(i * 4));
      check("s1_instr_addr", qat(del_addr, i), 32'(i * 4));
      check("s1_instr_data", qat(del_data, i), memf(32'(i * 4)));
    end
    if (del_cyc.size() >= 3) begin
      check("s1_throughput_a", {31'd0, (del_cyc[1] - del_cyc[0] <= 3)}, 32'd1);
      check("s1_throughput_b", {31'd0, (del_cyc[2] - del_cyc[1] <= 3)}, 32'd1);
    end

    // Request back-pressure while stall toggles
    do_reset();
    run_until_del(1);
    imem_req_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      stall = (i % 2 == 0);
      cycle();
      check("s2_req_valid", {31'd0, imem_req_valid}, 32'd1);
      check("s2_req_addr", imem_req_addr, 32'h4);
    end
    check("s2_no_extra_req", 32'(req_log.size()), 32'd1);
    stall = 1'b0;
    imem_req_ready = 1'b1;
    run_until_del(2);
    check("s2_instr_addr", qat(del_addr, 1), 32'h4);
    check("s2_req_count", 32'(req_log.size()), 32'd2);

    // Redirect while waiting on a slow response for 0x8
    do_reset();
    lat = 2;
    run_until_req(3);
    check("s3_req_8", qat(req_log, 2), 32'h8);
    watch_addr = 32'h8;
    shown_watch = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 32'h100;
    cycle();
    redirect_valid = 1'b0;
    run_until_del(3);
    check("s3_next_req", qat(req_log, 3), 32'h100);
    check("s3_instr_addr", qat(del_addr, 2), 32'h100);
    check("s3_instr_data", qat(del_data, 2), memf(32'h100));
    check("s3_never_shown", {31'd0, shown_watch}, 32'd0);

    // Redirect coinciding with the response
    do_reset();
    run_until_req(2);
    check("s4_rsp_pending", {31'd0, imem_rsp_valid}, 32'd1);
    watch_addr = 32'h4;
    shown_watch = 1'b0;
    redirect_valid = 1'b1;
    redirect_addr = 32'h200;
    cycle();
    redirect_valid = 1'b0;
    check("s4_req_valid", {31'd0, imem_req_valid}, 32'd1);
    check("s4_req_addr", imem_req_addr, 32'h200);
    run_until_del(2);
    check("s4_instr_addr", qat(del_addr, 1), 32'h200);
    check("s4_never_shown", {31'd0, shown_watch}, 32'd0);

    // Decode back-pressure in HOLD, then a clk_en freeze
    do_reset();
    instr_ready = 1'b0;
    run_until_ivalid();
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("s5_hold_valid", {31'd0, instr_valid}, 32'd1);
      check("s5_hold_data", instr_data, memf(32'h0));
      check("s5_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    check("s5_req_count", 32'(req_log.size()), 32'd1);
    clk_en = 1'b0;
    instr_ready = 1'b1;
    redirect_valid = 1'b1;
    redirect_addr = 32'h500;
    for (int i = 0; i < 2; i++) begin
      cycle();
      check("s5_freeze_valid", {31'd0, instr_valid}, 32'd1);
      check("s5_freeze_addr", instr_addr, 32'h0);
    end
    clk_en = 1'b1;
    redirect_valid = 1'b0;
    cycle();
    check("s5_popped", {31'd0, instr_valid}, 32'd0);
    run_until_req(2);
    check("s5_next_req", qat(req_log, 1), 32'h4);

    // Misaligned redirect
    do_reset();
    instr_ready = 1'b0;
    run_until_ivalid();
    redirect_valid = 1'b1;
    redirect_addr = 32'h102;
    cycle();
    redirect_valid = 1'b0;
    instr_ready = 1'b1;
`ifdef FETCH_SEQ_MISALIGN_TRAP_EN
    check("s6_fault_pulse", {31'd0, misalign_fault}, 32'd1);
    check("s6_ivalid_off", {31'd0, instr_valid}, 32'd0);
    cycle();
    check("s6_fault_end", {31'd0, misalign_fault}, 32'd0);
    for (int i = 0; i < 5; i++) begin
      cycle();
      check("s6_no_req", {31'd0, imem_req_valid}, 32'd0);
    end
    check("s6_req_count", 32'(req_log.size()), 32'd1);
    redirect_valid = 1'b1;
    redirect_addr = 32'h300;
    cycle();
    redirect_valid = 1'b0;
    check("s6_aligned_nofault", {31'd0, misalign_fault}, 32'd0);
    run_until_req(2);
    check("s6_next_req", qat(req_log, 1), 32'h300);
`else
    check("s6_no_fault", {31'd0, misalign_fault}, 32'd0);
    run_until_req(2);
    check("s6_next_req", qat(req_log, 1), 32'h100);
`endif

    // Stray response in IDLE, then pc wrap at the top of the address space
    stall = 1'b1;
    do_reset();
    cycle();
    cycle();
    check("s7_idle_no_req", {31'd0, imem_req_valid}, 32'd0);
    imem_rsp_valid = 1'b1;
    imem_rsp_data = 32'hDEAD_BEEF;
    cycle();
    cycle();
    check("s7_stray_rsp", {31'd0, instr_valid}, 32'd0);
    redirect_valid = 1'b1;
    redirect_addr = 32'hFFFF_FFFC;
    cycle();
    redirect_valid = 1'b0;
    check("s7_idle_redirect", {31'd0, imem_req_valid}, 32'd0);
    stall = 1'b0;
    run_until_del(2);
    check("s7_req_top", qat(req_log, 0), 32'hFFFF_FFFC);
    check("s7_req_wrap", qat(req_log, 1), 32'h0);
    check("s7_del_wrap", qat(del_addr, 1), 32'h0);
    check("s7_data_wrap", qat(del_data, 1), memf(32'h0));

    // Randomized back-pressure, stall, clk_en and latency; stream must stay sequential
    do_reset();
    rand_lat = 1'b1;
    for (int i = 0; i < 400; i++) begin
      stall          = ($urandom_range(0, 3) == 0);
      instr_ready    = ($urandom_range(0, 1) == 1);
      imem_req_ready = ($urandom_range(0, 2) != 0);
      clk_en         = ($urandom_range(0, 7) != 0);
      cycle();
    end
    stall = 1'b0;
    instr_ready = 1'b1;
    imem_req_ready = 1'b1;
    clk_en = 1'b1;
    for (int i = 0; i < 12; i++) cycle();
    check("rnd_progress", {31'd0, (del_addr.size() >= 10)}, 32'd1);
    for (int i = 0; i < req_log.size(); i++) begin
      check("rnd_req_addr", req_log[i], 32'(i * 4));
    end
    for (int i = 0; i < del_addr.size(); i++) begin
      check("rnd_instr_addr", del_addr[i], 32'(i * 4));
      check("rnd_instr_data", del_data[i], memf(32'(i * 4)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
